// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage <-> divide sequencer handshake and operand/result bus
interface div_seq_if #(parameter int DW = 32);
  logic          start_i;
  logic          annul_i;
  logic          signed_div_i;
  logic [DW-1:0] opdata1_i;
  logic [DW-1:0] opdata2_i;
  logic [2*DW-1:0] result_o;
  logic          ready_o;
  logic          stallreq_o;
  modport master(output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
                 input result_o, ready_o, stallreq_o);
  modport slave(input start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
                output result_o, ready_o, stallreq_o);
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU with pipeline stall
module div_seq #(parameter int DW = 32) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST = CW'(DW);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2*DW:0]   work, work_n;
  logic [DW-1:0]   dvs, dvs_n;
  logic            neg_q, neg_q_n, neg_r, neg_r_n;
  logic [2*DW-1:0] result, result_n;
  logic            ready, ready_n;
  logic [DW-1:0]   a_abs, b_abs, sub, q, r;
  logic            ge, take;
  assign bus.result_o = result;
  assign bus.ready_o = ready;
  assign take = bus.start_i && !bus.annul_i;
  assign bus.stallreq_o = (state == ON) || (state == BYZERO) || (state == FREE && take);
  // next-state, datapath step and sign correction
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    work_n = work;
    dvs_n = dvs;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    result_n = result;
    ready_n = ready;
    a_abs = (bus.signed_div_i && bus.opdata1_i[DW-1]) ? -bus.opdata1_i : bus.opdata1_i;
    b_abs = (bus.signed_div_i && bus.opdata2_i[DW-1]) ? -bus.opdata2_i : bus.opdata2_i;
    ge = work[2*DW:DW] >= {1'b0, dvs};
    sub = work[2*DW-1:DW] - dvs;
    q = neg_q ? -work[DW-1:0] : work[DW-1:0];
    r = neg_r ? -work[2*DW:DW+1] : work[2*DW:DW+1];
    case (state)
      FREE: if (take) begin
        if (~|bus.opdata2_i) state_n = BYZERO;
        else begin
          state_n = ON;
          cnt_n = '0;
          work_n = {{DW{1'b0}}, a_abs, 1'b0};
          dvs_n = b_abs;
          neg_q_n = bus.signed_div_i && (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
          neg_r_n = bus.signed_div_i && bus.opdata1_i[DW-1];
        end
      end
      BYZERO: begin
        state_n = bus.annul_i ? FREE : END;
        result_n = '0;
        ready_n = !bus.annul_i;
      end
      ON: if (bus.annul_i) begin
        state_n = FREE;
        cnt_n = '0;
        result_n = '0;
        ready_n = 1'b0;
      end else if (cnt == LAST) begin
        state_n = END;
        cnt_n = '0;
        result_n = {r, q};
        ready_n = 1'b1;
      end else begin
        work_n = ge ? {sub, work[DW-1:0], 1'b1} : {work[2*DW-1:0], 1'b0};
        cnt_n = cnt + 1'b1;
      end
      END: if (!bus.start_i) begin
        state_n = FREE;
        result_n = '0;
        ready_n = 1'b0;
      end
      default: state_n = FREE;
    endcase
  end
  // state and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FREE;
      cnt <= '0;
      work <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      work <= work_n;
      dvs <= dvs_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      result <= result_n;
      ready <= ready_n;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq with directed and random divides
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] expq[$];
  logic ready_q = 1'b0;
  div_seq_if #(32) bus();
  div_seq #(.DW(32)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (b == 0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // monitor: compare every fresh result against the oldest expectation
  always @(negedge clk) begin
    if (bus.ready_o && !ready_q) begin
      if (expq.size() == 0) chk("unexpected_result", bus.result_o, 64'hx);
      else chk("result", bus.result_o, expq.pop_front());
    end
    ready_q = bus.ready_o;
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b0;
    bus.signed_div_i = s;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    #1 chk("stall_at_start", 64'(bus.stallreq_o), 64'd1);
    expq.push_back(ref_div(a, b, s));
    @(posedge clk);
    n = 1;
    #1;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    bus.signed_div_i = $urandom_range(0, 1);
    forever begin
      @(negedge clk);
      if (bus.ready_o) break;
      if (n >= 100) begin
        chk("ready_timeout", 64'(n), 64'(b == 0 ? 2 : 34));
        break;
      end
      @(posedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(b == 0 ? 2 : 34));
    chk("stall_in_end", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    chk("ready_held", 64'(bus.ready_o), 64'd1);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1 chk("ready_drop", 64'(bus.ready_o), 64'd0);
    chk("result_clear", bus.result_o, 64'd0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b1;
    do_div(32'd100, 32'd7, 1'b0);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1);
    do_div(32'd7, 32'hFFFFFFFE, 1'b1);
    do_div(32'h12345678, 32'd0, 1'b0);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
    do_div(32'hFFFFFFFF, 32'd1, 1'b0);
    do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_div(32'h80000000, 32'd0, 1'b1);
    // annul in FREE blocks accept
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    #1 chk("annul_free_stall", 64'(bus.stallreq_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("annul_free_blocked", 64'(bus.stallreq_o), 64'd0);
    // annul at edge 10 of an ON run
    @(negedge clk);
    bus.annul_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("on_stall", 64'(bus.stallreq_o), 64'd1);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1 chk("annul_ready", 64'(bus.ready_o), 64'd0);
    chk("annul_result", bus.result_o, 64'd0);
    chk("annul_stall", 64'(bus.stallreq_o), 64'd0);
    bus.annul_i = 1'b0;
    do_div(32'd9, 32'd3, 1'b0);
    // async reset mid-ON, then a fresh divide must take full latency
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    repeat (12) @(posedge clk);
    #2 rst = 1'b0;
    bus.start_i = 1'b0;
    #1 chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_on_result", bus.result_o, 64'd0);
    chk("rst_on_stall", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_div(32'd100, 32'd7, 1'b0);
    // async reset while a result is held clears it at once
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.opdata1_i = 32'd77;
    bus.opdata2_i = 32'd5;
    expq.push_back(ref_div(32'd77, 32'd5, 1'b0));
    repeat (36) @(posedge clk);
    #2 chk("end_result_before_rst", bus.result_o, {32'd2, 32'd15});
    rst = 1'b0;
    bus.start_i = 1'b0;
    #1 chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_end_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      do_div(a, b, 1'($urandom_range(0, 1)));
    end
    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
